tow_match_score: RTL and testbench
==================================

# tow_match_score

Parametrised score keeper for the tug-of-war game. A single instance tracks both players: the rope position across a configurable LED row, round wins, per-player round counts and match completion after a configurable number of rounds. It sits between the per-player push-input conditioning (edge detect/debounce) and the LED/HEX display drivers. It replaces the fixed four-LED per-player scorer.

## Interface
Parameters:
- POSITIONS, default 9: number of rope LEDs; odd, ≥3.
- ROUNDS_TO_WIN, default 3: rounds a player must win to take the match; ≥1.
- HOLD_CYCLES, default 4: cycles the winning LED is held after a round before the rope recentres; ≥1.
- SCORE_W, local, $clog2(ROUNDS_TO_WIN+1): score width.

Ports (the `reset` port is active-low, asynchronous):
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  active-low asynchronous reset.
- idle  in  1  freeze; while high, no state changes (hold counter included).
- restart  in  1  synchronous new-match request.
- push_l  in  1  one-cycle left-player push pulse.
- push_r  in  1  one-cycle right-player push pulse.
- pattern  out  POSITIONS  rope LED pattern; bit POSITIONS-1 is the left end.
- score_l  out  SCORE_W  left rounds won.
- score_r  out  SCORE_W  right rounds won.
- round_win_l  out  1  one-cycle pulse when left wins a round.
- round_win_r  out  1  one-cycle pulse when right wins a round.
- match_win_l  out  1  level; left has won the match.
- match_win_r  out  1  level; right has won the match.

## Operation
- State: FSM {PLAY, HOLD, OVER}, position register pos (0..POSITIONS-1), hold counter, two score counters, two round-win pulse registers. CENTRE = (POSITIONS-1)/2.
- Reset (reset=0): state PLAY, pos=CENTRE, scores 0, all pulses and match flags 0, pattern = one-hot at CENTRE.
- Priority per edge: reset > restart > idle > normal.
- restart: scores 0, pos=CENTRE, hold counter 0, state PLAY. Accepted in any state, including while idle is high.
- PLAY:
  - push_l alone: pos+1.
  - push_r alone: pos-1.
  - Both pushes, or neither: pos unchanged.
  - push_l alone at pos=POSITIONS-1: left wins the round. score_l+1, round_win_l pulses, pos unchanged.
  - push_r alone at pos=0: the mirror case for the right player.
  - After a round win, go to OVER if the new score equals ROUNDS_TO_WIN, else to HOLD with the counter loaded to HOLD_CYCLES.
- HOLD: pushes ignored; counter decrements each non-idle cycle. When it reaches 0: pos=CENTRE and state PLAY, in the same edge.
- OVER: pattern all ones. match_win_x stays at 1 for the winner. Pushes ignored; scores frozen. Exit only via restart or reset.
- pattern: one-hot at pos in PLAY and HOLD; all ones in OVER.
- Scores never exceed ROUNDS_TO_WIN and never wrap.
- match_win_l and match_win_r are never both 1.

## Timing
- All outputs are decoded from registers only; there are no input-to-output combinational paths.
- Push latency: a push sampled at edge k is visible on pattern and pos in the cycle after edge k.
- Round win: in the cycle after the winning edge:
  - score updated;
  - round_win_x = 1 for exactly one cycle;
  - state HOLD, or OVER.
- match_win_x rises in that same cycle when the round decides the match.
- The HOLD state lasts exactly HOLD_CYCLES non-idle cycles. The recentred pattern appears in the next cycle.
- idle high: all registers hold. round_win pulses are still cleared after one cycle, so a pulse never stretches.
- Asynchronous reset takes effect immediately, mid-HOLD or mid-OVER. Release is assumed synchronised upstream.

## Test plan
Parameters for all scenarios: POSITIONS=5, ROUNDS_TO_WIN=2, HOLD_CYCLES=3.
- Reset, then release: pattern=00100, scores 0, all flags 0.
- Movement and ties: push_l, push_l → pattern 01000, then 10000. Push both in one cycle → unchanged. push_r → 01000.
- Round win: from 10000, push_l → round_win_l high for one cycle, score_l=1, pattern 10000 held 3 cycles, then 00100. Pushes during HOLD have no effect.
- Match win: left wins a second round → score_l=2, match_win_l=1, pattern 11111. Further pushes ignored. restart → 00100, scores 0, flags 0.
- idle freeze: assert idle mid-HOLD for 5 cycles → counter, pattern and scores frozen, and pushes ignored. Deassert → remaining hold cycles complete.
- Async reset: assert reset between clock edges during OVER → outputs return to reset values before the next posedge.

Source files
------------

// File: rtl/tow_match_score.sv
// Tug-of-war score keeper: rope position, round wins, per-player scores and
// match completion for both players, with registered outputs throughout.
module tow_match_score #(
    parameter int POSITIONS     = 9,
    parameter int ROUNDS_TO_WIN = 3,
    parameter int HOLD_CYCLES   = 4,
    localparam int SCORE_W      = $clog2(ROUNDS_TO_WIN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 idle,
    input  logic                 restart,
    input  logic                 push_l,
    input  logic                 push_r,
    output logic [POSITIONS-1:0] pattern,
    output logic [SCORE_W-1:0]   score_l,
    output logic [SCORE_W-1:0]   score_r,
    output logic                 round_win_l,
    output logic                 round_win_r,
    output logic                 match_win_l,
    output logic                 match_win_r
);

    localparam int POS_W = $clog2(POSITIONS);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [POS_W-1:0]     POS_MAX    = POS_W'(POSITIONS - 1);
    localparam logic [POS_W-1:0]     POS_CENTRE = POS_W'((POSITIONS - 1) / 2);
    localparam logic [SCORE_W-1:0]   SCORE_MAX  = SCORE_W'(ROUNDS_TO_WIN);
    localparam logic [CNT_W-1:0]     HOLD_LOAD  = CNT_W'(HOLD_CYCLES);
    localparam logic [POSITIONS-1:0] PAT_ONE    = {{(POSITIONS - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HOLD = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    function automatic logic [POSITIONS-1:0] rope_leds(input logic [POS_W-1:0] pos,
                                                       input logic             over);
        if (over) begin
            return '1;
        end else begin
            return PAT_ONE << pos;
        end
    endfunction

    state_t               r_state,     w_state_nxt;
    logic [POS_W-1:0]     r_pos,       w_pos_nxt;
    logic [CNT_W-1:0]     r_hold_cnt,  w_hold_cnt_nxt;
    logic [SCORE_W-1:0]   r_score_l,   w_score_l_nxt;
    logic [SCORE_W-1:0]   r_score_r,   w_score_r_nxt;
    logic                 r_win_l,     w_win_l_nxt;
    logic                 r_win_r,     w_win_r_nxt;
    logic                 r_match_l,   w_match_l_nxt;
    logic                 r_match_r,   w_match_r_nxt;
    logic [POSITIONS-1:0] r_pattern,   w_pattern_nxt;
    logic                 w_push_l_only;
    logic                 w_push_r_only;

    assign w_push_l_only = push_l & ~push_r;
    assign w_push_r_only = push_r & ~push_l;

    // Next-state logic: restart beats idle, idle freezes everything but the win pulses.
    always_comb begin
        w_state_nxt    = r_state;
        w_pos_nxt      = r_pos;
        w_hold_cnt_nxt = r_hold_cnt;
        w_score_l_nxt  = r_score_l;
        w_score_r_nxt  = r_score_r;
        w_win_l_nxt    = 1'b0;
        w_win_r_nxt    = 1'b0;

        if (restart) begin
            w_state_nxt    = ST_PLAY;
            w_pos_nxt      = POS_CENTRE;
            w_hold_cnt_nxt = CNT_W'(0);
            w_score_l_nxt  = SCORE_W'(0);
            w_score_r_nxt  = SCORE_W'(0);
        end else if (idle) begin
            w_state_nxt = r_state;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (w_push_l_only) begin
                        if (r_pos == POS_MAX) begin
                            // Saturating increment keeps the score inside its legal range.
                            if (r_score_l != SCORE_MAX) begin
                                w_score_l_nxt = r_score_l + SCORE_W'(1);
                            end else begin
                                w_score_l_nxt = r_score_l;
                            end
                            w_win_l_nxt = 1'b1;
                            if (w_score_l_nxt == SCORE_MAX) begin
                                w_state_nxt = ST_OVER;
                            end else begin
                                w_state_nxt    = ST_HOLD;
                                w_hold_cnt_nxt = HOLD_LOAD;
                            end
                        end else begin
                            w_pos_nxt = r_pos + POS_W'(1);
                        end
                    end else if (w_push_r_only) begin
                        if (r_pos == POS_W'(0)) begin
                            if (r_score_r != SCORE_MAX) begin
                                w_score_r_nxt = r_score_r + SCORE_W'(1);
                            end else begin
                                w_score_r_nxt = r_score_r;
                            end
                            w_win_r_nxt = 1'b1;
                            if (w_score_r_nxt == SCORE_MAX) begin
                                w_state_nxt = ST_OVER;
                            end else begin
                                w_state_nxt    = ST_HOLD;
                                w_hold_cnt_nxt = HOLD_LOAD;
                            end
                        end else begin
                            w_pos_nxt = r_pos - POS_W'(1);
                        end
                    end else begin
                        w_pos_nxt = r_pos;
                    end
                end
                ST_HOLD: begin
                    // The last hold cycle recentres the rope on the same edge it expires.
                    if (r_hold_cnt <= CNT_W'(1)) begin
                        w_hold_cnt_nxt = CNT_W'(0);
                        w_pos_nxt      = POS_CENTRE;
                        w_state_nxt    = ST_PLAY;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt - CNT_W'(1);
                    end
                end
                ST_OVER: begin
                    w_state_nxt = ST_OVER;
                end
                default: begin
                    w_state_nxt    = ST_PLAY;
                    w_pos_nxt      = POS_CENTRE;
                    w_hold_cnt_nxt = CNT_W'(0);
                end
            endcase
        end
    end

    // Output decode from next-state values so every output is a flop.
    always_comb begin
        w_pattern_nxt = rope_leds(w_pos_nxt, (w_state_nxt == ST_OVER));
        w_match_l_nxt = (w_state_nxt == ST_OVER) && (w_score_l_nxt == SCORE_MAX);
        w_match_r_nxt = (w_state_nxt == ST_OVER) && (w_score_r_nxt == SCORE_MAX)
                        && (w_score_l_nxt != SCORE_MAX);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_PLAY;
            r_pos      <= POS_CENTRE;
            r_hold_cnt <= CNT_W'(0);
            r_score_l  <= SCORE_W'(0);
            r_score_r  <= SCORE_W'(0);
            r_win_l    <= 1'b0;
            r_win_r    <= 1'b0;
            r_match_l  <= 1'b0;
            r_match_r  <= 1'b0;
            r_pattern  <= PAT_ONE << POS_CENTRE;
        end else begin
            r_state    <= w_state_nxt;
            r_pos      <= w_pos_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_score_l  <= w_score_l_nxt;
            r_score_r  <= w_score_r_nxt;
            r_win_l    <= w_win_l_nxt;
            r_win_r    <= w_win_r_nxt;
            r_match_l  <= w_match_l_nxt;
            r_match_r  <= w_match_r_nxt;
            r_pattern  <= w_pattern_nxt;
        end
    end

    assign pattern     = r_pattern;
    assign score_l     = r_score_l;
    assign score_r     = r_score_r;
    assign round_win_l = r_win_l;
    assign round_win_r = r_win_r;
    assign match_win_l = r_match_l;
    assign match_win_r = r_match_r;

endmodule

// File: tb/tb_tow_match_score.sv
// Scoreboard bench for tow_match_score: directed game scenarios then random play,
// each cycle's expected outputs queued by the driver and checked by a monitor.
module tb_tow_match_score;

    localparam int P = 5;
    localparam int R = 2;
    localparam int H = 3;
    localparam int C = (P - 1) / 2;

    typedef struct packed {
        logic [P-1:0] pat;
        logic [1:0]   sl;
        logic [1:0]   sr;
        logic         wl;
        logic         wr;
        logic         ml;
        logic         mr;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         idle = 1'b0;
    logic         restart = 1'b0;
    logic         push_l = 1'b0;
    logic         push_r = 1'b0;
    logic [P-1:0] pattern;
    logic [1:0]   score_l;
    logic [1:0]   score_r;
    logic         round_win_l;
    logic         round_win_r;
    logic         match_win_l;
    logic         match_win_r;

    int n_pass = 0;
    int n_total = 0;
    exp_t exp_q[$];

    // Reference game state: plain integers following the game rules.
    int m_pos = C;
    int m_sl = 0;
    int m_sr = 0;
    int m_hold_left = 0;
    bit m_over = 1'b0;

    tow_match_score #(.POSITIONS(P), .ROUNDS_TO_WIN(R), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(reset), .idle(idle), .restart(restart),
        .push_l(push_l), .push_r(push_r), .pattern(pattern),
        .score_l(score_l), .score_r(score_r),
        .round_win_l(round_win_l), .round_win_r(round_win_r),
        .match_win_l(match_win_l), .match_win_r(match_win_r)
    );

    always #5 clk = ~clk;

    function automatic exp_t reset_values();
        exp_t e;
        e.pat = P'(1) << C;
        e.sl = 2'd0; e.sr = 2'd0;
        e.wl = 1'b0; e.wr = 1'b0; e.ml = 1'b0; e.mr = 1'b0;
        return e;
    endfunction

    function automatic exp_t actual_outputs();
        exp_t a;
        a.pat = pattern; a.sl = score_l; a.sr = score_r;
        a.wl = round_win_l; a.wr = round_win_r;
        a.ml = match_win_l; a.mr = match_win_r;
        return a;
    endfunction

    task automatic compare(input string name, input exp_t act, input exp_t ex);
        n_total++;
        if (act === ex) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got pat=%b sl=%0d sr=%0d rwl=%b rwr=%b mwl=%b mwr=%b, expected pat=%b sl=%0d sr=%0d rwl=%b rwr=%b mwl=%b mwr=%b",
                     name, $time, act.pat, act.sl, act.sr, act.wl, act.wr, act.ml, act.mr,
                     ex.pat, ex.sl, ex.sr, ex.wl, ex.wr, ex.ml, ex.mr);
        end
    endtask

    task automatic model_reset();
        m_pos = C; m_sl = 0; m_sr = 0; m_hold_left = 0; m_over = 1'b0;
    endtask

    // Drive inputs for the coming posedge and queue the outputs that edge must produce.
    task automatic apply(input bit pl, input bit pr, input bit id, input bit rs, input bit rn);
        exp_t e;
        bit wl = 1'b0;
        bit wr = 1'b0;
        push_l = pl; push_r = pr; idle = id; restart = rs; reset = rn;
        if (!rn || rs) begin
            model_reset();
        end else if (id || m_over) begin
            m_pos = m_pos;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_pos = C;
        end else if (pl && !pr) begin
            if (m_pos == P - 1) begin
                m_sl++; wl = 1'b1;
                if (m_sl == R) m_over = 1'b1; else m_hold_left = H;
            end else begin
                m_pos++;
            end
        end else if (pr && !pl) begin
            if (m_pos == 0) begin
                m_sr++; wr = 1'b1;
                if (m_sr == R) m_over = 1'b1; else m_hold_left = H;
            end else begin
                m_pos--;
            end
        end
        e.pat = m_over ? {P{1'b1}} : (P'(1) << m_pos);
        e.sl = 2'(m_sl); e.sr = 2'(m_sr);
        e.wl = wl; e.wr = wr;
        e.ml = m_over && (m_sl == R);
        e.mr = m_over && (m_sr == R);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit pl, input bit pr, input bit id = 1'b0, input bit rs = 1'b0,
                         input bit rn = 1'b1);
        @(negedge clk);
        apply(pl, pr, id, rs, rn);
    endtask

    // Monitor: one output set per posedge, checked just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                compare("cycle_check", actual_outputs(), exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset held for two edges, then released.
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0);
        // Movement and ties.
        cycle(1, 0); cycle(1, 0); cycle(1, 1); cycle(0, 1); cycle(1, 0);
        // Left round win, then pushes during hold.
        cycle(1, 0);
        cycle(1, 0); cycle(0, 1); cycle(1, 0);
        cycle(0, 0);
        // Second left round decides the match; pushes then ignored; restart.
        cycle(1, 0); cycle(1, 0); cycle(1, 0);
        cycle(1, 0); cycle(0, 1); cycle(0, 0);
        cycle(0, 0, 0, 1);
        // Idle freeze in the middle of a hold.
        cycle(1, 0); cycle(1, 0); cycle(1, 0);
        cycle(0, 0);
        for (int i = 0; i < 5; i++) cycle(i[0], ~i[0], 1'b1);
        cycle(0, 0); cycle(0, 0); cycle(0, 0);
        // Right round win also exercised, then left wins to reach match over.
        cycle(0, 1); cycle(0, 1); cycle(0, 1);
        cycle(0, 0); cycle(0, 0); cycle(0, 0);
        cycle(1, 0); cycle(1, 0); cycle(1, 0);
        cycle(0, 0);
        // Asynchronous reset between edges during match over.
        @(negedge clk);
        push_l = 1'b0; push_r = 1'b0; idle = 1'b0; restart = 1'b0;
        #2 reset = 1'b0;
        #1 compare("async_reset", actual_outputs(), reset_values());
        apply(0, 0, 0, 0, 0);
        cycle(0, 0);
        // Restart accepted while idle is high.
        cycle(1, 0); cycle(1, 0, 1, 1); cycle(0, 0);
        // Random play.
        for (int i = 0; i < 1500; i++) begin
            bit pl, pr, id, rs, rn;
            pl = ($urandom_range(0, 99) < 55);
            pr = ($urandom_range(0, 99) < 40);
            id = ($urandom_range(0, 99) < 10);
            rs = ($urandom_range(0, 99) < 3);
            rn = ($urandom_range(0, 199) != 0);
            cycle(pl, pr, id, rs, rn);
        end
        // Drain scoreboard with a bounded wait.
        @(negedge clk);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
